load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Big-endian load/store unit between the CPU and a one-word-per-cycle data memory.
// Sub-word stores do a read-modify-write of the enclosing word.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] mem_readData
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, WRITE, DONE, ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        bad;
    logic        word_st;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    logic [31:0] merged;

    assign bad = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (addr[1:0] != 2'b00));
    assign word_st = we & (size == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_next = ERR;
                    end else if (word_st) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = we_q ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        memRead    = (state == READ);
        memWrite   = (state == WRITE);
        done       = (state == DONE) || (state == ERR);
        misaligned = (state == ERR);
    end

    // Lane extraction: byte offset 0 is the most significant byte.
    always_comb begin
        lane_b = 8'h00;
        case (off_q)
            2'd0:    lane_b = mem_readData[31:24];
            2'd1:    lane_b = mem_readData[23:16];
            2'd2:    lane_b = mem_readData[15:8];
            default: lane_b = mem_readData[7:0];
        endcase
        lane_h = off_q[1] ? mem_readData[15:0]
                          : mem_readData[31:16];
    end

    always_comb begin
        ld_val = mem_readData;
        merged = mem_readData;
        case (size_q)
            2'b00: begin
                ld_val = uns_q ? {24'h0, lane_b}
                               : {{24{lane_b[7]}}, lane_b};
                case (off_q)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                ld_val = uns_q ? {16'h0, lane_h}
                               : {{16{lane_h[15]}}, lane_h};
                if (off_q[1]) begin
                    merged[15:0] = wdata_q[15:0];
                end else begin
                    merged[31:16] = wdata_q[15:0];
                end
            end
            default: begin
                ld_val = mem_readData;
                merged = mem_readData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            off_q         <= 2'b00;
            size_q        <= 2'b00;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            wdata_q       <= 32'h0;
            rdata         <= 32'h0;
            mem_address   <= 32'h0;
            mem_writeData <= 32'h0;
        end else begin
            if (state == IDLE && req) begin
                off_q         <= addr[1:0];
                size_q        <= size;
                we_q          <= we;
                uns_q         <= unsigned_ld;
                wdata_q       <= wdata;
                mem_address   <= {addr[31:2], 2'b00};
                mem_writeData <= wdata;
            end
            if (state == WAIT) begin
                if (we_q) begin
                    mem_writeData <= merged;
                end else begin
                    rdata <= ld_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read word memory model.
// Expected values are hand-computed big-endian results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] mem_readData = 32'h0;

    bit [31:0]   mem [16];
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_both = 0;
    logic [31:0] w_addr = 32'h0;
    logic [31:0] w_data = 32'h0;

    int checks = 0;
    int failures = 0;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .size          (size),
        .unsigned_ld   (unsigned_ld),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .busy          (busy),
        .done          (done),
        .misaligned    (misaligned),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .mem_readData  (mem_readData)
    );

    always #5 clk = ~clk;

    // Data memory: read data appears the cycle after the memRead cycle.
    always @(posedge clk) begin
        if (memWrite) begin
            mem[mem_address[5:2]] <= mem_writeData;
            n_wr   <= n_wr + 1;
            w_addr <= mem_address;
            w_data <= mem_writeData;
        end
        if (memRead) begin
            mem_readData <= mem[mem_address[5:2]];
            n_rd         <= n_rd + 1;
        end
        if (memRead && memWrite) begin
            n_both <= n_both + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Accepts one request, returns cycles from accept edge to done sample.
    task automatic run_op(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic mis);
        @(posedge clk);
        #1;
        req         = 1'b1;
        we          = w;
        size        = sz;
        unsigned_ld = u;
        addr        = a;
        wdata       = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        mis = misaligned;
    endtask

    int          lat;
    logic        mis;
    int          rd0;
    int          wr0;
    int          done_at [$];
    int          rd_cnt;
    logic [31:0] busy_trace;

    initial begin
        reset = 1'b1;
        req = 1'b0;
        we = 1'b0;
        size = 2'b00;
        unsigned_ld = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        busy_trace = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {27'h0, busy, done, misaligned, memRead, memWrite},
            32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_maddr", mem_address, 32'h0);
        chk("rst_mwdata", mem_writeData, 32'h0);
        reset = 1'b0;

        // sw 0x0777DFF0 -> 0x10
        wr0 = n_wr; rd0 = n_rd;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0777DFF0, lat, mis);
        chk("sw_lat", lat, 2);
        chk("sw_nwr", n_wr - wr0, 1);
        chk("sw_nrd", n_rd - rd0, 0);
        chk("sw_waddr", w_addr, 32'h10);
        chk("sw_wdata", w_data, 32'h0777DFF0);
        chk("sw_rdata", rdata, 32'h0);

        rd0 = n_rd;
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("lw_lat", lat, 3);
        chk("lw_rdata", rdata, 32'h0777DFF0);
        chk("lw_nrd", n_rd - rd0, 1);

        // sb: only wdata[7:0] lands in lane 1
        wr0 = n_wr; rd0 = n_rd;
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AB, lat, mis);
        chk("sb_lat", lat, 4);
        chk("sb_wdata", w_data, 32'h07ABDFF0);
        chk("sb_nrd", n_rd - rd0, 1);
        chk("sb_nwr", n_wr - wr0, 1);
        chk("sb_rdata", rdata, 32'h0777DFF0);

        run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, mis);
        chk("lb_11", rdata, 32'hFFFFFFAB);
        run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, mis);
        chk("lbu_11", rdata, 32'h000000AB);
        run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("lb_10", rdata, 32'h00000007);

        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, lat, mis);
        chk("sh_lat", lat, 4);
        chk("sh_wdata", w_data, 32'h07AB8001);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, mis);
        chk("lh_12", rdata, 32'hFFFF8001);
        run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, mis);
        chk("lhu_12", rdata, 32'h00008001);
        run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("lh_10", rdata, 32'h000007AB);
        run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, mis);
        chk("lb_13", rdata, 32'h00000001);

        // misaligned / illegal: no strobes, rdata held at 0x00000001
        wr0 = n_wr; rd0 = n_rd;
        run_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, mis);
        chk("lw11_lat", lat, 1);
        chk("lw11_mis", mis, 1);
        run_op(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, mis);
        chk("lh13_lat", lat, 1);
        chk("lh13_mis", mis, 1);
        run_op(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("sz11_lat", lat, 1);
        chk("sz11_mis", mis, 1);
        chk("err_nrd", n_rd - rd0, 0);
        chk("err_nwr", n_wr - wr0, 0);
        chk("err_rdata", rdata, 32'h00000001);

        // reset during WAIT of sb 0xCD -> 0x10
        wr0 = n_wr;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; size = 2'b00;
        addr = 32'h10; wdata = 32'h000000CD;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rwait_busy", busy, 0);
        chk("rwait_done", done, 0);
        chk("rwait_rdata", rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rwait_nwr", n_wr - wr0, 0);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, mis);
        chk("rwait_lw", rdata, 32'h07AB8001);

        // req held high for 10 cycles
        rd0 = n_rd;
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; size = 2'b10;
        unsigned_ld = 1'b0; addr = 32'h10;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) req = 1'b0;
            busy_trace[c] = busy;
            if (done) done_at.push_back(c);
        end
        rd_cnt = n_rd - rd0;
        chk("hold_ndone", done_at.size(), 3);
        chk("hold_nrd", rd_cnt, 3);
        if (done_at.size() == 3) begin
            chk("hold_gap1", done_at[1] - done_at[0], 4);
            chk("hold_gap2", done_at[2] - done_at[1], 4);
        end
        chk("hold_busy", busy_trace[12:1], 12'b011101110111);
        chk("hold_rdata", rdata, 32'h07AB8001);
        chk("never_both", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
